// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle ARM-subset controller: state encoding,
// datapath select codes, ALU command decode and the condition-code evaluator.
package multicycle_controller_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // nzcv is {N,Z,C,V}; the NV encoding never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_main_fsm.sv
// Instruction sequencer: state register plus per-state raw control decode.
// Strobes leave here ungated; the top applies the condition and reset gating.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4
// DECODE | read registers, compute PC+8, latch condition result
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory
// EXECR  | ALU operation, register operand
// EXECI  | ALU operation, immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | compute branch target into PC
module multicycle_controller_main_fsm
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic       funct_i,
  input  logic       funct_l,
  output logic       irw,
  output logic       next_pc,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       decode
);

  logic [STATE_W-1:0] state, next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    irw        = 1'b0;
    next_pc    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    alu_op     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    decode     = 1'b0;
    case (state)
      S_FETCH: begin
        irw        = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        decode     = 1'b1;
        case (op)
          OP_MEM:   next_state = S_MEMADR;
          OP_DP:    next_state = funct_i ? S_EXECI : S_EXECR;
          OP_BR:    next_state = S_BRANCH;
          OP_UNDEF: next_state = S_FETCH;
          default:  next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b  = SRCB_IMM;
        next_state = funct_l ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR: begin
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b  = SRCB_IMM;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        branch     = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: sequencer, ALU decode, NZCV flags and
// condition gating of every architectural write strobe.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags
);

  logic       irw, next_pc, alu_op, reg_w, mem_w, branch, decode;
  logic       cond_ex_q, cmd_ok, pcs;
  logic [1:0] flag_w;

  multicycle_controller_main_fsm #(.STATE_W(STATE_W)) u_main_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (Op),
    .funct_i    (Funct[5]),
    .funct_l    (Funct[0]),
    .irw        (irw),
    .next_pc    (next_pc),
    .adr_src    (AdrSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .result_src (ResultSrc),
    .alu_op     (alu_op),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .branch     (branch),
    .decode     (decode)
  );

  // Unknown commands fall back to add and must not touch the flags.
  always_comb begin
    ALUControl = ALU_ADD;
    cmd_ok     = 1'b0;
    if (alu_op) begin
      case (Funct[4:1])
        CMD_ADD: begin ALUControl = ALU_ADD; cmd_ok = 1'b1; end
        CMD_SUB: begin ALUControl = ALU_SUB; cmd_ok = 1'b1; end
        CMD_AND: begin ALUControl = ALU_AND; cmd_ok = 1'b1; end
        CMD_ORR: begin ALUControl = ALU_ORR; cmd_ok = 1'b1; end
        default: begin ALUControl = ALU_ADD; cmd_ok = 1'b0; end
      endcase
    end
    flag_w[1] = Funct[0] & cmd_ok;
    flag_w[0] = Funct[0] & cmd_ok & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
  end

  // cond_ex_q is sampled only in DECODE, so an EXEC flag update cannot
  // retroactively cancel the same instruction's writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_ex_q <= 1'b0;
      Flags     <= 4'b0000;
    end else begin
      if (decode) cond_ex_q <= cond_eval(Cond, Flags);
      if (flag_w[1] & cond_ex_q) Flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex_q) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs      = ((Rd == 4'd15) & reg_w) | branch;
  assign PCWrite  = rst_n & (next_pc | (pcs & cond_ex_q));
  assign IRWrite  = rst_n & irw;
  assign RegWrite = rst_n & reg_w & cond_ex_q;
  assign MemWrite = rst_n & mem_w & cond_ex_q;

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset core.
- Decodes the latched instruction fields and sequences fetch/decode/execute/writeback through a 10-state FSM.
- Holds the NZCV status flags and evaluates the condition field against them.
- Gates every architectural write strobe (PC, register file, memory, flags) with the condition result.

Parameters:
- STATE_W, 4, width of the state register (10 states encoded).

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- Cond  in  4  instruction bits [31:28].
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20] (I, cmd[3:0], S/L).
- Rd  in  4  instruction bits [15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- AdrSrc  out  1  0=PC, 1=ALU result to memory address.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result.
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  {Op==01, Op==10}.
- Flags  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (rst_n low, async): state=FETCH, Flags=0000, cond_ex_q=0. While rst_n is low, PCWrite/IRWrite/RegWrite/MemWrite are forced 0.
- All outputs except Flags are combinational from state and instruction fields. No cycle advances during reset.
- FSM transitions on the clk rising edge:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latch cond_ex_q<=CondEx (computed from Cond and current Flags). Next: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH with no strobes.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next: Funct[0]=1->MEMRD, else MEMWR.
  - MEMRD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. Next: FETCH.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next: ALUWB.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1. Next: FETCH.
- Unlisted controls are 0 in every state.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11. Any other code->00 with FlagW=00.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
- Condition codes: EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL as ARM; 1111 gives CondEx=0.
- Gating:
  - PCS = (Rd==15 & RegW) | Branch.
  - PCWrite = NextPC | (PCS & cond_ex_q).
  - RegWrite = RegW & cond_ex_q; MemWrite = MemW & cond_ex_q.
- Flags update at the clk edge ending EXECR/EXECI:
  - N,Z <= ALUFlags[3:2] if FlagW[1] & cond_ex_q.
  - C,V <= ALUFlags[1:0] if FlagW[0] & cond_ex_q.
- Boundary: a flag update in EXEC never alters cond_ex_q for the same instruction's ALUWB, because cond_ex_q is latched only in DECODE.
- Latencies (cycles per instruction): LDR 5, STR 4, data-processing 4, branch 3, undefined 2.

Decomposition:
- Shared package: state encoding constants, ALUControl codes, ResultSrc/ALUSrcB selects, condition mnemonics.
- Sub-module main_fsm: state register plus per-state control decode.
- Top level holds the ALU decoder, Flags and cond_ex_q registers, and condition evaluation via the codebase's existing conditionals block.

Test Plan:
- Reset: assert rst_n=0 during MEMWB -> state=FETCH, Flags=0000, all strobes 0 immediately. First cycle after release -> PCWrite=1, IRWrite=1.
- LDR (Op=01, Funct=011001, Cond=1110) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB. RegWrite=1 only in MEMWB, ResultSrc=01, AdrSrc=1 in MEMRD.
- STREQ (Cond=0000, Funct[0]=0) with Flags Z=0 -> 4 cycles, MemWrite=0 throughout. With Z=1 -> MemWrite=1 in MEMWR.
- SUBS (Op=00, Funct=000101, Cond=1110) with ALUFlags=0100 -> ALUControl=01 in EXECR, Flags=0100 after EXECR. Next ADDEQ (Funct=001000, Cond=0000) -> RegWrite=1 in ALUWB.
- Flag race: SUBNE with S (Funct=000101, Cond=0001), Flags Z=0, ALUFlags=0100 -> cond_ex_q=1, Flags become Z=1, RegWrite still 1 in ALUWB.
- Branch BLT (Op=10, Cond=1011): Flags N=1,V=0 -> PCWrite=1 in BRANCH; Flags=0000 -> PCWrite=0. Data-processing with Rd=15, Cond=1110 -> PCWrite=1 in ALUWB.
